rush3d_command_sequencer: RTL and testbench
===========================================

Name: rush3d_command_sequencer

Overview:
Parametrised next-generation command controller for the rush3d pipeline. It decodes command bits from the host control/status register and sequences background fill, vertex clocking and buffer swaps. It acknowledges each command by writing the register back with that bit cleared. Generalises to N-way buffer rotation (double/triple buffering), synchronises swaps to the vsync rising edge, and exposes frame count and busy status.

Parameters:
CSR_WIDTH, 64, width of control_status_in/out (min 17)
NUM_BUFFERS, 2, framebuffer count, legal 2..4
BUF_IDX_WIDTH, 2, width of buffer index outputs
FRAME_CNT_WIDTH, 16, width of frame_count
TIMEOUT_CYCLES, 24'd2000000, swap watchdog limit (used only with SWAP_TIMEOUT_EN)

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
control_status_in  in  CSR_WIDTH  host CSR; bit0 VALID_VERTICES, bit4 BACKGROUND, bit8 SWAP_BUFFER
control_status_out  out  CSR_WIDTH  write-back value for CSR
control_status_load  out  1  CSR write-back enable, level, held until bit seen cleared
fill_background_flag  out  1  level, high during background fill
vertex_strobe  out  1  one-cycle pulse per accepted vertex command
draw_buffer_index  out  BUF_IDX_WIDTH  buffer being rendered
display_buffer_index  out  BUF_IDX_WIDTH  buffer being scanned out
frame_count  out  FRAME_CNT_WIDTH  completed swaps, wraps
busy  out  1  high in any state other than IDLE
framebuffer_write_state  in  4  4'h3 = background write active
rasteriser_state  in  4  4'h0 = idle
pixel_fifo_empty  in  1  pixel FIFO empty
vertex_data_fifo_empty  in  1  vertex FIFO empty
vsync  in  1  raw vsync level, synchronous to clock

Behaviour:
- Reset (asynchronous assert, any time including mid-command): all outputs 0, display index 0, draw index 1, frame_count 0, vsync_d 0, state IDLE. Pending CSR bits are re-sampled after reset.
- vsync_d registers vsync every cycle. vsync_rise = vsync & ~vsync_d.
- States: IDLE, BG_FILL, VERTS, SWAP_WAIT, SWAP_ACK.
- Priority in IDLE: BACKGROUND > VALID_VERTICES > SWAP. One command is accepted per IDLE cycle; the others stay pending in the CSR.
- IDLE, bit4 set -> BG_FILL. Same edge: fill_background_flag=1, load=1, out=in with bit4 cleared.
- BG_FILL: once bit4 reads 0, load<=0. Then, on a cycle with bit4=0 and framebuffer_write_state==4'h3, fill_background_flag<=0 and -> IDLE.
- IDLE, bit0 set -> VERTS. vertex_strobe=1 for exactly one cycle, load=1, out=in with bit0 cleared.
- VERTS: vertex_strobe=0. Once bit0 reads 0, load<=0 and -> IDLE. Minimum 2 cycles between strobes.
- IDLE, bit8 set -> SWAP_WAIT; no write-back yet.
- SWAP_WAIT: swap fires on a cycle where vsync_rise, pixel_fifo_empty, vertex_data_fifo_empty and rasteriser_state==0 all hold. On that edge:
  - display_buffer_index <= draw_buffer_index
  - draw_buffer_index <= (draw+1) mod NUM_BUFFERS
  - frame_count += 1, wrapping at 2^FRAME_CNT_WIDTH
  - load=1, out=in with bit8 cleared, -> SWAP_ACK
- vsync held high does not trigger a swap; only a rising edge does. A rise with the pipeline not idle is missed, and the swap waits for the next rise.
- SWAP_ACK: once bit8 reads 0, load<=0 and -> IDLE.
- Rotation examples: NUM_BUFFERS=2 gives display 0->1->0. NUM_BUFFERS=3 gives display 0->1->2->0 and draw 1->2->0->1.
- Bits other than 0/4/8 pass through control_status_out unchanged, except bit16 (see optional feature).
- Default case: -> IDLE, load<=0.

Optional Feature:
RUSH3D_SWAP_TIMEOUT_EN:
- Defined: a 24-bit watchdog clears on SWAP_WAIT entry and increments each cycle in SWAP_WAIT. When it reaches TIMEOUT_CYCLES-1 without a swap, a forced swap fires on the next cycle (same updates as a normal swap), ignoring the vsync and idle conditions. control_status_out bit16 is set to 1 as a sticky timeout flag; the host clears it.
- Undefined: no counter, bit16 passes through, SWAP_WAIT can wait forever.

Test Plan:
1. CSR=0x10, framebuffer_write_state=3 two cycles after load drops -> fill flag high 1 cycle after, out=0x0, load clears after bit4 reads 0, fill flag low, busy 0.
2. CSR=0x11 -> background served first, out=0x01. After IDLE, vertex_strobe pulses exactly 1 cycle, out=0x0.
3. NUM_BUFFERS=3, CSR=0x100 issued three times with FIFOs empty, raster idle, vsync pulsing -> display 1,2,0, draw 2,0,1, frame_count=3.
4. vsync already high on entry to SWAP_WAIT -> no swap until vsync falls and rises again. A rise while pixel_fifo_empty=0 -> no swap.
5. Reset asserted in SWAP_WAIT after one swap -> all outputs 0, display 0, draw 1 immediately (asynchronous).
6. With RUSH3D_SWAP_TIMEOUT_EN and TIMEOUT_CYCLES=100, vsync stuck low -> forced swap 100 cycles after entry, out bit16=1, bit8=0.

Source files
------------

// File: rtl/rush3d_command_sequencer.sv
// Command sequencer for the rush3d pipeline: background fill, vertex strobes and N-way buffer swaps on vsync.
// Optional swap watchdog enabled by defining RUSH3D_SWAP_TIMEOUT_EN.
module rush3d_command_sequencer #(
  parameter int          CSR_WIDTH       = 64,
  parameter int          NUM_BUFFERS     = 2,
  parameter int          BUF_IDX_WIDTH   = 2,
  parameter int          FRAME_CNT_WIDTH = 16,
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd2000000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [CSR_WIDTH-1:0]       control_status_in,
  output logic [CSR_WIDTH-1:0]       control_status_out,
  output logic                       control_status_load,
  output logic                       fill_background_flag,
  output logic                       vertex_strobe,
  output logic [BUF_IDX_WIDTH-1:0]   draw_buffer_index,
  output logic [BUF_IDX_WIDTH-1:0]   display_buffer_index,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       busy,
  input  logic [3:0]                 framebuffer_write_state,
  input  logic [3:0]                 rasteriser_state,
  input  logic                       pixel_fifo_empty,
  input  logic                       vertex_data_fifo_empty,
  input  logic                       vsync
);

  // state       | meaning
  // S_IDLE      | waiting for a command bit in the CSR
  // S_BG_FILL   | background fill running, waiting for ack and framebuffer write state
  // S_VERTS     | vertex strobe issued, waiting for host to clear bit0
  // S_SWAP_WAIT | swap requested, waiting for vsync rise with idle pipeline
  // S_SWAP_ACK  | swap done, waiting for host to clear bit8
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BG_FILL   = 3'd1,
    S_VERTS     = 3'd2,
    S_SWAP_WAIT = 3'd3,
    S_SWAP_ACK  = 3'd4
  } state_t;

  localparam int BIT_VERT = 0;
  localparam int BIT_BG   = 4;
  localparam int BIT_SWAP = 8;
  localparam logic [CSR_WIDTH-1:0]     MASK_VERT = CSR_WIDTH'(1) << BIT_VERT;
  localparam logic [CSR_WIDTH-1:0]     MASK_BG   = CSR_WIDTH'(1) << BIT_BG;
  localparam logic [CSR_WIDTH-1:0]     MASK_SWAP = CSR_WIDTH'(1) << BIT_SWAP;
  localparam logic [BUF_IDX_WIDTH-1:0] LAST_BUF  = BUF_IDX_WIDTH'(NUM_BUFFERS - 1);

  state_t                     state, state_nxt;
  logic [CSR_WIDTH-1:0]       csr_out_nxt;
  logic                       load_nxt, fill_nxt, strobe_nxt;
  logic [BUF_IDX_WIDTH-1:0]   draw_nxt, disp_nxt;
  logic [FRAME_CNT_WIDTH-1:0] frame_nxt;
  logic                       vsync_d;
  logic                       vsync_rise, pipe_idle, swap_go, bg_done;

  assign vsync_rise = vsync & ~vsync_d;
  assign pipe_idle  = pixel_fifo_empty & vertex_data_fifo_empty & (rasteriser_state == 4'h0);
  assign bg_done    = ~control_status_in[BIT_BG] & (framebuffer_write_state == 4'h3);
  assign busy       = (state != S_IDLE);

`ifdef RUSH3D_SWAP_TIMEOUT_EN
  localparam int BIT_TIMEOUT = 16;
  logic [23:0] wdog_q;
  logic        force_swap;

  assign force_swap = (wdog_q == TIMEOUT_CYCLES - 24'd1);
  assign swap_go    = (vsync_rise & pipe_idle) | force_swap;

  // Counter sits at zero outside SWAP_WAIT, so it starts fresh on every entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 wdog_q <= '0;
    else if (state != S_SWAP_WAIT) wdog_q <= '0;
    else                          wdog_q <= wdog_q + 24'd1;
  end
`else
  logic [23:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign swap_go        = vsync_rise & pipe_idle;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                <= S_IDLE;
      control_status_out   <= '0;
      control_status_load  <= 1'b0;
      fill_background_flag <= 1'b0;
      vertex_strobe        <= 1'b0;
      draw_buffer_index    <= BUF_IDX_WIDTH'(1);
      display_buffer_index <= '0;
      frame_count          <= '0;
      vsync_d              <= 1'b0;
    end else begin
      state                <= state_nxt;
      control_status_out   <= csr_out_nxt;
      control_status_load  <= load_nxt;
      fill_background_flag <= fill_nxt;
      vertex_strobe        <= strobe_nxt;
      draw_buffer_index    <= draw_nxt;
      display_buffer_index <= disp_nxt;
      frame_count          <= frame_nxt;
      vsync_d              <= vsync;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (control_status_in[BIT_BG])        state_nxt = S_BG_FILL;
        else if (control_status_in[BIT_VERT]) state_nxt = S_VERTS;
        else if (control_status_in[BIT_SWAP]) state_nxt = S_SWAP_WAIT;
      end
      S_BG_FILL:   if (bg_done) state_nxt = S_IDLE;
      S_VERTS:     if (!control_status_in[BIT_VERT]) state_nxt = S_IDLE;
      S_SWAP_WAIT: if (swap_go) state_nxt = S_SWAP_ACK;
      S_SWAP_ACK:  if (!control_status_in[BIT_SWAP]) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    csr_out_nxt = control_status_out;
    load_nxt    = control_status_load;
    fill_nxt    = fill_background_flag;
    strobe_nxt  = 1'b0;
    draw_nxt    = draw_buffer_index;
    disp_nxt    = display_buffer_index;
    frame_nxt   = frame_count;
    case (state)
      S_IDLE: begin
        if (control_status_in[BIT_BG]) begin
          fill_nxt    = 1'b1;
          load_nxt    = 1'b1;
          csr_out_nxt = control_status_in & ~MASK_BG;
        end else if (control_status_in[BIT_VERT]) begin
          strobe_nxt  = 1'b1;
          load_nxt    = 1'b1;
          csr_out_nxt = control_status_in & ~MASK_VERT;
        end
      end
      S_BG_FILL: begin
        if (!control_status_in[BIT_BG]) load_nxt = 1'b0;
        if (bg_done)                    fill_nxt = 1'b0;
      end
      S_VERTS: begin
        if (!control_status_in[BIT_VERT]) load_nxt = 1'b0;
      end
      S_SWAP_WAIT: begin
        if (swap_go) begin
          disp_nxt    = draw_buffer_index;
          draw_nxt    = (draw_buffer_index == LAST_BUF) ? '0
                                                        : draw_buffer_index + BUF_IDX_WIDTH'(1);
          frame_nxt   = frame_count + FRAME_CNT_WIDTH'(1);
          load_nxt    = 1'b1;
          csr_out_nxt = control_status_in & ~MASK_SWAP;
`ifdef RUSH3D_SWAP_TIMEOUT_EN
          if (force_swap) csr_out_nxt[BIT_TIMEOUT] = 1'b1;
`endif
        end
      end
      S_SWAP_ACK: begin
        if (!control_status_in[BIT_SWAP]) load_nxt = 1'b0;
      end
      default: load_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rush3d_command_sequencer.sv
// Scoreboard bench for rush3d_command_sequencer (3-buffer rotation, 64-bit CSR).
// Define RUSH3D_SWAP_TIMEOUT_EN to also exercise the forced-swap path.
module tb_rush3d_command_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [63:0] csr;
  logic [63:0] control_status_out;
  logic        control_status_load, fill_background_flag, vertex_strobe, busy;
  logic [1:0]  draw_buffer_index, display_buffer_index;
  logic [15:0] frame_count;
  logic [3:0]  fws, rast;
  logic        pix_empty, vtx_empty, vsync;

  initial forever #5 clock = ~clock;

  rush3d_command_sequencer #(
    .CSR_WIDTH(64), .NUM_BUFFERS(3), .BUF_IDX_WIDTH(2),
    .FRAME_CNT_WIDTH(16), .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .control_status_in(csr), .control_status_out(control_status_out),
    .control_status_load(control_status_load),
    .fill_background_flag(fill_background_flag), .vertex_strobe(vertex_strobe),
    .draw_buffer_index(draw_buffer_index), .display_buffer_index(display_buffer_index),
    .frame_count(frame_count), .busy(busy),
    .framebuffer_write_state(fws), .rasteriser_state(rast),
    .pixel_fifo_empty(pix_empty), .vertex_data_fifo_empty(vtx_empty), .vsync(vsync)
  );

  typedef struct {
    logic [63:0] out;
    logic        fill;
    logic        strobe;
    logic [1:0]  draw;
    logic [1:0]  disp;
    logic [15:0] frame;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  logic load_prev = 1'b0;
  logic strobe_prev = 1'b0;

  logic [1:0]  tbl_disp [3] = '{2'd1, 2'd2, 2'd0};
  logic [1:0]  tbl_draw [3] = '{2'd2, 2'd0, 2'd1};
  logic [15:0] tbl_frame[3] = '{16'd1, 16'd2, 16'd3};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ack(input logic [63:0] out, input logic fill, input logic strobe,
                            input logic [1:0] draw, input logic [1:0] disp, input logic [15:0] frame);
    exp_t e;
    e.out = out; e.fill = fill; e.strobe = strobe;
    e.draw = draw; e.disp = disp; e.frame = frame;
    sb.push_back(e);
  endtask

  // Host model: whenever the sequencer asks for a write-back, the CSR takes the new value.
  task automatic tick();
    @(negedge clock);
    if (control_status_load) csr = control_status_out;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(!busy && !control_status_load && !csr[0] && !csr[4] && !csr[8]) && n < 400);
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL %s_timeout got=busy expected=idle", name);
    end
  endtask

  task automatic wait_load(input logic level, input string name);
    int n = 0;
    while (control_status_load !== level && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s_timeout got=%0b expected=%0b", name, control_status_load, level);
    end
  endtask

  // Monitor: every new write-back is matched against the next scoreboard entry.
  initial forever begin
    @(negedge clock);
    if (control_status_load && !load_prev) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack got=0x%0h expected=none", control_status_out);
      end else begin
        mon_e = sb.pop_front();
        check("ack_csr_out", control_status_out, mon_e.out);
        check("ack_fill",    64'(fill_background_flag), 64'(mon_e.fill));
        check("ack_strobe",  64'(vertex_strobe), 64'(mon_e.strobe));
        check("ack_draw",    64'(draw_buffer_index), 64'(mon_e.draw));
        check("ack_disp",    64'(display_buffer_index), 64'(mon_e.disp));
        check("ack_frame",   64'(frame_count), 64'(mon_e.frame));
      end
    end
    if (vertex_strobe) begin
      check("strobe_one_cycle", 64'(strobe_prev), 64'd0);
      strobe_cnt++;
    end
    load_prev   = control_status_load;
    strobe_prev = vertex_strobe;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_out"},   control_status_out, 64'd0);
    check({tag, "_load"},  64'(control_status_load), 64'd0);
    check({tag, "_fill"},  64'(fill_background_flag), 64'd0);
    check({tag, "_strobe"},64'(vertex_strobe), 64'd0);
    check({tag, "_draw"},  64'(draw_buffer_index), 64'd1);
    check({tag, "_disp"},  64'(display_buffer_index), 64'd0);
    check({tag, "_frame"}, 64'(frame_count), 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd0);
  endtask

  initial begin
    int base;
    int n;
    reset_n = 1'b0; csr = '0; fws = 4'h0; rast = 4'h0;
    pix_empty = 1'b1; vtx_empty = 1'b1; vsync = 1'b0;
    tick(); tick();
    check_reset_state("reset");
    reset_n = 1'b1;
    tick();

    // Background fill alone
    expect_ack(64'h0, 1'b1, 1'b0, 2'd1, 2'd0, 16'd0);
    csr = 64'h10;
    wait_load(1'b1, "bg_load_rise");
    wait_load(1'b0, "bg_load_fall");
    check("bg_fill_held", 64'(fill_background_flag), 64'd1);
    check("bg_busy_held", 64'(busy), 64'd1);
    tick(); tick();
    fws = 4'h3;
    tick();
    check("bg_fill_done", 64'(fill_background_flag), 64'd0);
    check("bg_busy_done", 64'(busy), 64'd0);
    fws = 4'h0;

    // Background beats vertices; vertices follow
    fws = 4'h3;
    base = strobe_cnt;
    expect_ack(64'h01, 1'b1, 1'b0, 2'd1, 2'd0, 16'd0);
    expect_ack(64'h00, 1'b0, 1'b1, 2'd1, 2'd0, 16'd0);
    csr = 64'h11;
    wait_idle("bg_then_vert");
    check("vert_strobe_count", 64'(strobe_cnt - base), 64'd1);
    fws = 4'h0;

    // Back-to-back vertex commands with pass-through bits
    base = strobe_cnt;
    expect_ack(64'h0000_00F0_0000_0002, 1'b0, 1'b1, 2'd1, 2'd0, 16'd0);
    csr = 64'h0000_00F0_0000_0003;
    wait_idle("vert_a");
    csr = 64'h1;
    expect_ack(64'h0, 1'b0, 1'b1, 2'd1, 2'd0, 16'd0);
    wait_idle("vert_b");
    check("vert_pair_count", 64'(strobe_cnt - base), 64'd2);
    csr = '0;

    // Three swaps rotate through all buffers
    for (int i = 0; i < 3; i++) begin
      expect_ack(64'hA5A5_0000_0000_0000, 1'b0, 1'b0, tbl_draw[i], tbl_disp[i], tbl_frame[i]);
      csr = 64'hA5A5_0000_0000_0100;
      tick(); tick();
      vsync = 1'b1;
      tick(); tick();
      vsync = 1'b0;
      wait_idle("swap_rot");
    end
    check("rot_disp_final",  64'(display_buffer_index), 64'd0);
    check("rot_draw_final",  64'(draw_buffer_index), 64'd1);
    check("rot_frame_final", 64'(frame_count), 64'd3);
    csr = '0;

    // vsync already high, then rises with busy pipeline: no swap until clean rise
    vsync = 1'b1;
    tick(); tick();
    expect_ack(64'h0, 1'b0, 1'b0, 2'd2, 2'd1, 16'd4);
    csr = 64'h100;
    repeat (5) tick();
    check("vsync_high_no_swap", 64'(control_status_load), 64'd0);
    check("vsync_high_frame",   64'(frame_count), 64'd3);
    check("vsync_high_busy",    64'(busy), 64'd1);
    vsync = 1'b0;
    tick(); tick();
    pix_empty = 1'b0; vsync = 1'b1;
    tick(); tick();
    check("pix_busy_no_swap", 64'(frame_count), 64'd3);
    vsync = 1'b0; pix_empty = 1'b1; rast = 4'h2;
    tick(); tick();
    vsync = 1'b1;
    tick(); tick();
    check("rast_busy_no_swap", 64'(frame_count), 64'd3);
    vsync = 1'b0; rast = 4'h0;
    tick(); tick();
    vsync = 1'b1;
    wait_idle("swap_clean_rise");
    vsync = 1'b0;

    // Asynchronous reset in SWAP_WAIT
    csr = 64'h100;
    repeat (3) tick();
    check("pre_reset_busy", 64'(busy), 64'd1);
    #3 reset_n = 1'b0;
    #1 check_reset_state("async_reset");
    csr = '0;
    tick();
    reset_n = 1'b1;
    tick();
    expect_ack(64'h0, 1'b0, 1'b1, 2'd1, 2'd0, 16'd0);
    csr = 64'h1;
    wait_idle("vert_after_reset");

`ifdef RUSH3D_SWAP_TIMEOUT_EN
    // Forced swap with vsync stuck low: entry at the first edge, swap 100 edges later
    expect_ack(64'h0000_0000_0001_0000, 1'b0, 1'b0, 2'd2, 2'd1, 16'd1);
    csr = 64'h100;
    n = 0;
    do begin
      tick();
      n++;
    end while (!control_status_load && n < 500);
    check("timeout_latency", 64'(n - 1), 64'd100);
    wait_idle("timeout_swap");
    csr = '0;
`endif

    repeat (3) tick();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
